// File: rtl/dual_update.sv
// dual_update: streaming ADMM dual-variable update with primal-residual tracking.
// Each knot yields y' = y + x - v and g' = g + u - z, saturated to W bits. The
// infinity-norm residual max(|x - v|, |u - z|) is accumulated over the horizon,
// and a convergence flag compares it against the latched tolerance.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; inputs are ignored
// RUN   | accepting knots and emitting updated duals, one register stage
// DONE  | single cycle: done pulse, prim_res/converged updated
module dual_update #(
  parameter int STATE_DIM   = 12,
  parameter int CONTROL_DIM = 4,
  parameter int W           = 16,
  parameter int NHORIZON    = 10
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [W-1:0]                      tol,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [STATE_DIM-1:0][W-1:0]       x_k,
  input  logic [STATE_DIM-1:0][W-1:0]       v_k,
  input  logic [STATE_DIM-1:0][W-1:0]       y_k,
  input  logic [CONTROL_DIM-1:0][W-1:0]     u_k,
  input  logic [CONTROL_DIM-1:0][W-1:0]     z_k,
  input  logic [CONTROL_DIM-1:0][W-1:0]     g_k,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [STATE_DIM-1:0][W-1:0]       y_new,
  output logic [CONTROL_DIM-1:0][W-1:0]     g_new,
  output logic                              busy,
  output logic                              done,
  output logic [W-1:0]                      prim_res,
  output logic                              converged
);

  localparam int CW = $clog2(NHORIZON + 1);
  localparam logic [CW-1:0] NH = CW'(NHORIZON);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Three-operand sum evaluated two bits wider so y + x - v can never wrap
  // before saturation.
  function automatic logic [W-1:0] sat_sum(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [W-1:0] c);
    logic signed [W+1:0] s;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    smax = {3'b000, {(W-1){1'b1}}};
    smin = {3'b111, {(W-1){1'b0}}};
    s = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b})
        - $signed({{2{c[W-1]}}, c});
    if (s > smax)      sat_sum = {1'b0, {(W-1){1'b1}}};
    else if (s < smin) sat_sum = {1'b1, {(W-1){1'b0}}};
    else               sat_sum = s[W-1:0];
  endfunction

  // |a - c| at W+1 bits, clamped to the largest positive W-bit value.
  function automatic logic [W-1:0] sat_absdiff(input logic [W-1:0] a,
                                               input logic [W-1:0] c);
    logic signed [W:0] d;
    logic [W:0]        m;
    d = $signed({a[W-1], a}) - $signed({c[W-1], c});
    m = d[W] ? (~d + 1'b1) : d;
    if (m > {2'b00, {(W-1){1'b1}}}) sat_absdiff = {1'b0, {(W-1){1'b1}}};
    else                            sat_absdiff = m[W-1:0];
  endfunction

  state_t                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [W-1:0]                   runmax_q;
  logic [W-1:0]                   tol_q;
  logic                           busy_q;
  logic                           done_q;
  logic [W-1:0]                   prim_res_q;
  logic                           converged_q;
  logic                           out_valid_q;
  logic [STATE_DIM-1:0][W-1:0]    y_new_q;
  logic [CONTROL_DIM-1:0][W-1:0]  g_new_q;

  logic [STATE_DIM-1:0][W-1:0]    y_d;
  logic [CONTROL_DIM-1:0][W-1:0]  g_d;
  logic [W-1:0]                   knot_res_d;
  logic                           xfer;
  logic                           last_hs;

  // No skid buffer: accept only when the output slot is empty or draining.
  assign in_ready = (state_q == RUN) && (cnt_q < NH) && (!out_valid_q || out_ready);
  assign xfer     = in_valid && in_ready;
  // Output held in RUN with all knots accepted is necessarily the final one.
  assign last_hs  = (state_q == RUN) && out_valid_q && out_ready && (cnt_q == NH);

  // Per-lane dual updates and the knot's worst residual.
  always_comb begin
    logic [W-1:0] r;
    y_d        = '0;
    g_d        = '0;
    knot_res_d = '0;
    r          = '0;
    for (int i = 0; i < STATE_DIM; i++) begin
      y_d[i] = sat_sum(y_k[i], x_k[i], v_k[i]);
      r      = sat_absdiff(x_k[i], v_k[i]);
      if (r > knot_res_d) knot_res_d = r;
    end
    for (int j = 0; j < CONTROL_DIM; j++) begin
      g_d[j] = sat_sum(g_k[j], u_k[j], z_k[j]);
      r      = sat_absdiff(u_k[j], z_k[j]);
      if (r > knot_res_d) knot_res_d = r;
    end
  end

  // Pass sequencing, residual accumulation and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      runmax_q    <= '0;
      tol_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prim_res_q  <= '0;
      converged_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            cnt_q    <= '0;
            runmax_q <= '0;
            tol_q    <= tol;
            busy_q   <= 1'b1;
          end
        end
        RUN: begin
          if (xfer) begin
            cnt_q <= cnt_q + 1'b1;
            if (knot_res_d > runmax_q) runmax_q <= knot_res_d;
          end
          if (last_hs) begin
            state_q     <= DONE;
            done_q      <= 1'b1;
            prim_res_q  <= runmax_q;
            converged_q <= ($signed(runmax_q) <= $signed(tol_q));
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Single output stage; holds while downstream stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      y_new_q     <= '0;
      g_new_q     <= '0;
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      y_new_q     <= y_d;
      g_new_q     <= g_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign y_new     = y_new_q;
  assign g_new     = g_new_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign prim_res  = prim_res_q;
  assign converged = converged_q;

endmodule

// File: tb/tb_dual_update.sv
// Directed bench for dual_update: table-driven passes plus hand-written
// backpressure, protocol-guard and mid-pass reset sequences.
module tb_dual_update;

  localparam int SD = 12;
  localparam int CD = 4;
  localparam int W  = 16;
  localparam int NH = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   start;
  logic [W-1:0]           tol;
  logic                   in_valid;
  logic                   in_ready;
  logic [SD-1:0][W-1:0]   x_k, v_k, y_k;
  logic [CD-1:0][W-1:0]   u_k, z_k, g_k;
  logic                   out_valid;
  logic                   out_ready;
  logic [SD-1:0][W-1:0]   y_new;
  logic [CD-1:0][W-1:0]   g_new;
  logic                   busy;
  logic                   done;
  logic [W-1:0]           prim_res;
  logic                   converged;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dual_update #(.STATE_DIM(SD), .CONTROL_DIM(CD), .W(W), .NHORIZON(NH)) dut (
    .clk(clk), .reset(reset), .start(start), .tol(tol),
    .in_valid(in_valid), .in_ready(in_ready),
    .x_k(x_k), .v_k(v_k), .y_k(y_k), .u_k(u_k), .z_k(z_k), .g_k(g_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_new(y_new), .g_new(g_new),
    .busy(busy), .done(done), .prim_res(prim_res), .converged(converged)
  );

  typedef struct {
    logic [W-1:0] x, v, y, u, z, g;
    logic [W-1:0] ey, eg;
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] x, input logic [W-1:0] v, input logic [W-1:0] y,
                       input logic [W-1:0] u, input logic [W-1:0] z, input logic [W-1:0] g);
    for (int i = 0; i < SD; i++) begin
      x_k[i] = x; v_k[i] = v; y_k[i] = y;
    end
    for (int j = 0; j < CD; j++) begin
      u_k[j] = u; z_k[j] = z; g_k[j] = g;
    end
  endtask

  task automatic chk_out(input string nm, input logic [W-1:0] ey, input logic [W-1:0] eg);
    for (int i = 0; i < SD; i++) chk({nm, "_y"}, 32'(y_new[i]), 32'(ey));
    for (int j = 0; j < CD; j++) chk({nm, "_g"}, 32'(g_new[j]), 32'(eg));
  endtask

  task automatic run_pass(input int base, input logic [W-1:0] t,
                          input logic [W-1:0] exp_res, input logic exp_conv);
    tol = t;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pass_busy", 32'(busy), 32'd1);
    for (int k = 0; k < NH; k++) begin
      drive(tbl[base+k].x, tbl[base+k].v, tbl[base+k].y,
            tbl[base+k].u, tbl[base+k].z, tbl[base+k].g);
      in_valid = 1'b1;
      #1;
      chk("pass_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("pass_out_valid", 32'(out_valid), 32'd1);
      chk_out($sformatf("vec%0d", base + k), tbl[base+k].ey, tbl[base+k].eg);
    end
    in_valid = 1'b0;
    chk("pass_no_done_early", 32'(done), 32'd0);
    tick();
    chk("pass_done", 32'(done), 32'd1);
    chk("pass_prim_res", 32'(prim_res), 32'(exp_res));
    chk("pass_converged", 32'(converged), 32'(exp_conv));
    chk("pass_busy_in_done", 32'(busy), 32'd1);
    chk("pass_out_valid_drained", 32'(out_valid), 32'd0);
    tick();
    chk("pass_done_one_cycle", 32'(done), 32'd0);
    chk("pass_busy_cleared", 32'(busy), 32'd0);
    chk("pass_prim_res_hold", 32'(prim_res), 32'(exp_res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //         x        v        y        u        z        g        ey       eg
    tbl[0] = '{16'h0100, 16'h00C0, 16'h0010, 16'h0010, 16'h0020, 16'h0005, 16'h0050, 16'hFFF5};
    tbl[1] = '{16'h1234, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0007, 16'h0000, 16'h0007};
    tbl[2] = '{16'hFFF0, 16'hFFE0, 16'h0001, 16'h0000, 16'h0030, 16'h0000, 16'h0011, 16'hFFD0};
    tbl[3] = '{16'h0200, 16'hFF00, 16'h7F00, 16'h0000, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
    tbl[4] = '{16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF};
    tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'h8000, 16'h0000, 16'h8000};

    reset = 1'b0; start = 1'b0; tol = '0; in_valid = 1'b0; out_ready = 1'b1;
    drive('0, '0, '0, '0, '0, '0);
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prim_res", 32'(prim_res), 32'd0);
    chk("rst_converged", 32'(converged), 32'd0);
    chk_out("rst", 16'h0000, 16'h0000);
    reset = 1'b1;
    tick();

    // Pass A: worst residual 0x40 equals tol -> converged.
    run_pass(0, 16'h0040, 16'h0040, 1'b1);
    // Pass B: saturating knots; residual 0x7FFF exceeds tol 0x7FFE.
    run_pass(3, 16'h7FFE, 16'h7FFF, 1'b0);

    // Backpressure pass with a stray start during the stall.
    tol = 16'h0005;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(16'h0001, '0, '0, '0, '0, '0);
    in_valid = 1'b1;
    tick();
    chk("bp_first_valid", 32'(out_valid), 32'd1);
    chk_out("bp_first", 16'h0001, 16'h0000);
    out_ready = 1'b0;
    drive(16'h0002, '0, '0, '0, '0, '0);
    for (int c = 0; c < 3; c++) begin
      start = (c == 1);
      #1;
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      tick();
      chk("bp_valid_hold", 32'(out_valid), 32'd1);
      chk("bp_data_hold", 32'(y_new[0]), 32'h0001);
      chk("bp_data_hold_last", 32'(y_new[SD-1]), 32'h0001);
    end
    start = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_resume_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_second", 16'h0002, 16'h0000);
    drive(16'h0003, '0, '0, '0, '0, '0);
    tick();
    chk_out("bp_third", 16'h0003, 16'h0000);
    drive(16'h0004, '0, '0, '0, '0, '0);
    #1;
    chk("guard_full_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_prim_res", 32'(prim_res), 32'h0003);
    chk("bp_converged", 32'(converged), 32'd1);
    chk("guard_no_extra_knot", 32'(out_valid), 32'd0);
    tick();
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_done_cleared", 32'(done), 32'd0);

    // Inputs offered in IDLE are ignored.
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("idle_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
    end
    in_valid = 1'b0;

    // Mid-pass asynchronous reset with a pending output.
    tol = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    drive(16'h0010, '0, '0, '0, '0, '0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("mr_pre_valid", 32'(out_valid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_out_valid", 32'(out_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_prim_res", 32'(prim_res), 32'd0);
    chk("mr_converged", 32'(converged), 32'd0);
    chk("mr_in_ready", 32'(in_ready), 32'd0);
    chk("mr_y_new", 32'(y_new[0]), 32'd0);
    #1;
    reset = 1'b1;
    tick();
    run_pass(0, 16'h0040, 16'h0040, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dual_update.md
# dual_update

Streaming ADMM dual-variable update stage for the MPC solver datapath. It consumes, knot by knot over the horizon, the primal iterates (x, u), the freshly clipped slacks (v, z) and the current duals (y, g). It emits the updated duals y' = y + x − v and g' = g + u − z, saturated to W bits. It also tracks the infinity-norm primal residual over the whole horizon and raises a convergence flag against a tolerance. The stage sits directly downstream of the slack-clipping stage, and its y'/g' outputs feed the next ADMM iteration's slack inputs.

## Interface
- STATE_DIM, 12, state vector length
- CONTROL_DIM, 4, control vector length
- W, 16, signed fixed-point word width
- NHORIZON, 10, knots per ADMM iteration (≥1)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle pulse, begins an iteration pass; honoured only in IDLE
- tol  in  W  signed, primal-residual tolerance; sampled on accepted start
- in_valid  in  1  knot data valid
- in_ready  out  1  stage can accept a knot
- x_k, v_k, y_k  in  W×STATE_DIM  signed state, slack, dual
- u_k, z_k, g_k  in  W×CONTROL_DIM  signed control, slack, dual
- out_valid  out  1  updated duals valid
- out_ready  in  1  downstream accepts duals
- y_new  out  W×STATE_DIM  signed updated state dual
- g_new  out  W×CONTROL_DIM  signed updated control dual
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass
- prim_res  out  W  signed, non-negative max residual of last completed pass
- converged  out  1  prim_res ≤ tol for last completed pass

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start. On that edge: knot counter ← 0, running max ← 0, tol latched, busy ← 1.
- In RUN, a knot transfers on in_valid & in_ready.
- in_ready = (state==RUN) & (accepted-count < NHORIZON) & (!out_valid | out_ready).
- in_ready is 0 in IDLE and DONE. Inputs presented in those states are ignored.
- Per element: sum = y + x − v, evaluated at W+2 bits and saturated to [−2^(W−1), 2^(W−1)−1]. Controls are handled the same way with g, u, z.
- Per element residual: |x − v| and |u − z|, evaluated at W+1 bits and saturated to 2^(W−1)−1.
- Knot residual = max over all STATE_DIM + CONTROL_DIM elements.
- Running max ← max(running max, knot residual) on each transfer.
- RUN → DONE when the NHORIZON-th knot's output handshakes (out_valid & out_ready).
- DONE lasts exactly one cycle:
  - done = 1;
  - prim_res ← running max;
  - converged ← (running max ≤ tol);
  - busy ← 0;
  - next state is IDLE.
- start received in RUN or DONE is ignored. start in the same cycle as the DONE→IDLE transition is also ignored.
- prim_res and converged hold their values until the next DONE.

## Timing
- Reset values: in_ready 0, out_valid 0, y_new/g_new all 0, busy 0, done 0, prim_res 0, converged 0, state IDLE, counters 0.
- Reset mid-pass aborts the pass immediately; all outputs take their reset values.
- Latency: a knot accepted at edge t presents y_new/g_new with out_valid = 1 after edge t, i.e. one register stage.
- out_valid and data hold stable while out_ready = 0.
- Back-to-back throughput: one knot per cycle while out_ready = 1.
- in_ready is combinational from out_valid/out_ready; there is no skid buffer.
- done asserts in the cycle after the final output handshake.
- With out_ready held high, done asserts 2 cycles after the final input transfer.
- Minimum pass length: NHORIZON + 2 cycles after start (the start-to-RUN edge plus the DONE cycle).
- busy is high from the cycle after start through the DONE cycle.

## Test plan
- Single pass, NHORIZON=2, out_ready=1. Knot0: all x=0x0100, v=0x00C0, y=0x0010; knot1: x=v, y=0. Required: y_new = 0x0050 then 0x0000; prim_res = 0x0040; with tol=0x0040, converged = 1 and done pulses once.
- Saturation: y=0x7F00, x=0x0200, v=0xFF00 (−256). Required: y_new=0x7FFF. Residual |0x0200−(−256)| = 0x0300.
- Negative overflow: y=0x8000, x=0x8000, v=0x7FFF. Required: y_new=0x8000; residual saturates to 0x7FFF; converged = 0 for any tol < 0x7FFF.
- Backpressure: hold out_ready=0 for 3 cycles after the first transfer. Required: in_ready=0, out_valid and y_new stable, no second knot accepted. Releasing out_ready resumes one knot per cycle.
- Protocol guards:
  - start while busy does not restart the counter;
  - in_valid in IDLE leaves out_valid=0;
  - after NHORIZON transfers, in_ready stays 0 even with in_valid=1.
- Reset: assert reset (0) asynchronously mid-pass with out_valid=1. Required: out_valid, busy, done, prim_res and converged are 0 immediately. After release, a new start runs a full clean pass.
